// File: rtl/sdram_device_model.sv
// Cycle-accurate responder for the NanoMig 32-bit SDR SDRAM command bus.
// Tracks mode and bank state, stores write data, returns CAS-delayed reads, flags protocol errors.
module sdram_device_model #(
    parameter int MEM_AW = 10,
    parameter int T_RCD  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_cke,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [1:0]  sd_ba,
    input  logic [10:0] sd_addr,
    input  logic [3:0]  sd_dqm,
    input  logic [31:0] sd_data_in,
    output logic [31:0] sd_data_out,
    output logic [3:0]  sd_data_oe,
    output logic        mode_valid,
    output logic [1:0]  cas_lat,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] refresh_cnt
);
    localparam logic [2:0] CMD_NOP     = 3'b111;
    localparam logic [2:0] CMD_ACTIVE  = 3'b011;
    localparam logic [2:0] CMD_READ    = 3'b101;
    localparam logic [2:0] CMD_WRITE   = 3'b100;
    localparam logic [2:0] CMD_PRECH   = 3'b010;
    localparam logic [2:0] CMD_REFRESH = 3'b001;
    localparam logic [2:0] CMD_LMR     = 3'b000;
    localparam logic [7:0] TRCD_MAX    = 8'(T_RCD);

    logic [3:0]       open_q, open_d;
    logic [3:0][10:0] row_q, row_d;
    logic [3:0][7:0]  trcd_q, trcd_d;
    logic             mode_valid_q, mode_valid_d;
    logic [1:0]       cas_lat_q, cas_lat_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [15:0]      refresh_cnt_q, refresh_cnt_d;
    logic             p0_v_q, p0_v_d, p1_v_q, p1_v_d;
    logic [31:0]      p0_data_q, p0_data_d, p1_data_q, p1_data_d;
    logic [3:0]       p0_oe_q, p0_oe_d, p1_oe_q, p1_oe_d;
    logic [31:0]      data_out_q, data_out_d;
    logic [3:0]       data_oe_q, data_oe_d;

    logic [31:0]       mem_q [0:(1<<MEM_AW)-1];
    logic [2:0]        cmd_s;
    logic [2:0]        viol_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic [20:0]       full_addr_s;
    logic [MEM_AW-1:0] mem_idx_s;
    logic [31:0]       rd_word_s;
    logic              unused_addr_s;

    assign full_addr_s   = {sd_ba, row_q[sd_ba], sd_addr[7:0]};
    assign mem_idx_s     = full_addr_s[MEM_AW-1:0];
    assign unused_addr_s = ^full_addr_s;
    assign rd_word_s     = mem_q[mem_idx_s];

    // Command decode: bank/mode/refresh next state and violation code.
    always_comb begin
        cmd_s         = (sd_cke && !sd_cs) ? {sd_ras, sd_cas, sd_we} : CMD_NOP;
        open_d        = open_q;
        row_d         = row_q;
        mode_valid_d  = mode_valid_q;
        cas_lat_d     = cas_lat_q;
        refresh_cnt_d = refresh_cnt_q;
        viol_s        = 3'd0;
        wr_en_s       = 1'b0;
        rd_en_s       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (trcd_q[i] < TRCD_MAX) trcd_d[i] = trcd_q[i] + 8'd1;
            else                      trcd_d[i] = trcd_q[i];
        end
        case (cmd_s)
            CMD_ACTIVE: begin
                if (!mode_valid_q) begin
                    viol_s = 3'd6;
                end else begin
                    viol_s        = open_q[sd_ba] ? 3'd2 : 3'd0;
                    open_d[sd_ba] = 1'b1;
                    row_d[sd_ba]  = sd_addr;
                    trcd_d[sd_ba] = 8'd0;
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (!mode_valid_q) begin
                    viol_s = 3'd6;
                end else if (!open_q[sd_ba]) begin
                    viol_s = 3'd1;
                end else begin
                    // The counter reads k-1 on the k-th edge after ACTIVE.
                    viol_s  = ((trcd_q[sd_ba] + 8'd1) < TRCD_MAX) ? 3'd3 : 3'd0;
                    wr_en_s = (cmd_s == CMD_WRITE);
                    rd_en_s = (cmd_s == CMD_READ);
                    if (sd_addr[10]) open_d[sd_ba] = 1'b0;
                    else             open_d[sd_ba] = open_q[sd_ba];
                end
            end
            CMD_PRECH: begin
                if (sd_addr[10]) open_d        = 4'd0;
                else             open_d[sd_ba] = 1'b0;
            end
            CMD_REFRESH: begin
                viol_s = (open_q != 4'd0) ? 3'd4 : 3'd0;
                if (refresh_cnt_q != 16'hFFFF) refresh_cnt_d = refresh_cnt_q + 16'd1;
                else                           refresh_cnt_d = refresh_cnt_q;
            end
            CMD_LMR: begin
                if ((sd_addr[2:0] != 3'd0) || ((sd_addr[6:4] != 3'd2) && (sd_addr[6:4] != 3'd3))) begin
                    viol_s = 3'd5;
                end else begin
                    mode_valid_d = 1'b1;
                    cas_lat_d    = sd_addr[5:4];
                end
            end
            default: begin
                viol_s = 3'd0;
            end
        endcase
        err_d      = (viol_s != 3'd0);
        err_code_d = (err_code_q == 3'd0) ? viol_s : err_code_q;
    end

    // Read latency pipeline and output selection by CAS latency.
    always_comb begin
        p0_v_d    = rd_en_s;
        p0_data_d = rd_word_s;
        p0_oe_d   = ~sd_dqm;
        p1_v_d    = p0_v_q;
        p1_data_d = p0_data_q;
        p1_oe_d   = p0_oe_q;
        if (cas_lat_q == 2'd3) begin
            data_oe_d  = p1_v_q ? p1_oe_q : 4'd0;
            data_out_d = p1_v_q ? p1_data_q : 32'd0;
        end else begin
            data_oe_d  = p0_v_q ? p0_oe_q : 4'd0;
            data_out_d = p0_v_q ? p0_data_q : 32'd0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            open_q        <= 4'd0;
            row_q         <= '0;
            trcd_q        <= '0;
            mode_valid_q  <= 1'b0;
            cas_lat_q     <= 2'd2;
            err_q         <= 1'b0;
            err_code_q    <= 3'd0;
            refresh_cnt_q <= 16'd0;
            p0_v_q        <= 1'b0;
            p0_data_q     <= 32'd0;
            p0_oe_q       <= 4'd0;
            p1_v_q        <= 1'b0;
            p1_data_q     <= 32'd0;
            p1_oe_q       <= 4'd0;
            data_out_q    <= 32'd0;
            data_oe_q     <= 4'd0;
        end else begin
            open_q        <= open_d;
            row_q         <= row_d;
            trcd_q        <= trcd_d;
            mode_valid_q  <= mode_valid_d;
            cas_lat_q     <= cas_lat_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            refresh_cnt_q <= refresh_cnt_d;
            p0_v_q        <= p0_v_d;
            p0_data_q     <= p0_data_d;
            p0_oe_q       <= p0_oe_d;
            p1_v_q        <= p1_v_d;
            p1_data_q     <= p1_data_d;
            p1_oe_q       <= p1_oe_d;
            data_out_q    <= data_out_d;
            data_oe_q     <= data_oe_d;
        end
    end

    // Backing store survives reset; byte writes honour the DQM masks.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset && wr_en_s && !sd_dqm[i]) mem_q[mem_idx_s][8*i +: 8] <= sd_data_in[8*i +: 8];
        end
    end

    assign sd_data_out = data_out_q;
    assign sd_data_oe  = data_oe_q;
    assign mode_valid  = mode_valid_q;
    assign cas_lat     = cas_lat_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign refresh_cnt = refresh_cnt_q;
endmodule
